// File: rtl/synth_pkg.sv
// Shared synthesis constants and types for the phase-accumulator voice bank.
// Holds the default accumulator width, the A4 reference increment and the sweep FSM states.
package synth_pkg;

  localparam int DEFAULT_PHASE_W = 32;

  // 440 Hz increment for the reference sample-rate table
  localparam logic [31:0] A4_INC = 32'h0B43_9581;

  typedef enum logic {
    ST_IDLE,
    ST_SWEEP
  } sweep_state_t;

endpackage

// File: rtl/phase_voice_regs.sv
// Per-voice phase/increment/gate storage with one configuration write port
// and one read/modify port used by the sweep.
module phase_voice_regs #(
  parameter int VOICES  = 8,
  parameter int PHASE_W = 32,
  parameter int VOICE_W = $clog2(VOICES)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [VOICE_W-1:0] wr_voice,
  input  logic [PHASE_W-1:0] wr_inc,
  input  logic               wr_gate,
  input  logic               upd_en,
  input  logic [VOICE_W-1:0] upd_voice,
  input  logic [PHASE_W-1:0] upd_phase,
  output logic [PHASE_W-1:0] rd_phase,
  output logic [PHASE_W-1:0] rd_inc,
  output logic               rd_gate
);

  logic [PHASE_W-1:0] phase_arr [VOICES];
  logic [PHASE_W-1:0] inc_arr   [VOICES];
  logic               gate_arr  [VOICES];

  generate
    for (genvar gi = 0; gi < VOICES; gi++) begin : g_voice
      logic [PHASE_W-1:0] phase_reg;
      logic [PHASE_W-1:0] inc_reg;
      logic               gate_reg;

      // The write port is evaluated last so a note-on clear beats the accumulation.
      always_ff @(posedge clk) begin
        if (reset) begin
          phase_reg <= '0;
          inc_reg   <= '0;
          gate_reg  <= 1'b0;
        end else begin
          if (upd_en && upd_voice == VOICE_W'(gi))
            phase_reg <= upd_phase;
          if (wr_en && wr_voice == VOICE_W'(gi)) begin
            inc_reg  <= wr_inc;
            gate_reg <= wr_gate;
            if (wr_gate && !gate_reg)
              phase_reg <= '0;
          end
        end
      end

      assign phase_arr[gi] = phase_reg;
      assign inc_arr[gi]   = inc_reg;
      assign gate_arr[gi]  = gate_reg;
    end
  endgenerate

  // Read sees pre-write values, so a same-cycle write cannot affect this accumulation.
  assign rd_phase = phase_arr[upd_voice];
  assign rd_inc   = inc_arr[upd_voice];
  assign rd_gate  = gate_arr[upd_voice];

endmodule

// File: rtl/phase_bank.sv
// Multi-voice phase accumulator bank: each sample strobe sweeps all voices,
// one per cycle, and streams the post-increment phases out on a registered port.
module phase_bank
  import synth_pkg::*;
#(
  parameter int VOICES  = 8,
  parameter int PHASE_W = DEFAULT_PHASE_W,
  parameter int VOICE_W = $clog2(VOICES)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_sample_en,
  input  logic               i_wr_en,
  input  logic [VOICE_W-1:0] i_wr_voice,
  input  logic [PHASE_W-1:0] i_wr_inc,
  input  logic               i_wr_gate,
  output logic               o_valid,
  output logic [VOICE_W-1:0] o_voice,
  output logic [PHASE_W-1:0] o_phase,
  output logic               o_active,
  output logic               o_busy,
  output logic               o_overrun
);

  localparam logic [VOICE_W-1:0] LAST_VOICE = VOICE_W'(VOICES - 1);

  sweep_state_t       state_reg, state_next;
  logic [VOICE_W-1:0] voice_reg, voice_next;
  logic               busy;

  logic [PHASE_W-1:0] rd_phase, rd_inc, acc_phase;
  logic               rd_gate;

  logic               valid_reg, active_reg, overrun_reg;
  logic [VOICE_W-1:0] out_voice_reg;
  logic [PHASE_W-1:0] out_phase_reg;

  assign busy = (state_reg == ST_SWEEP);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      voice_reg <= '0;
    end else begin
      state_reg <= state_next;
      voice_reg <= voice_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    voice_next = voice_reg;
    case (state_reg)
      ST_IDLE: begin
        if (i_sample_en) begin
          state_next = ST_SWEEP;
          voice_next = '0;
        end
      end
      ST_SWEEP: begin
        if (voice_reg == LAST_VOICE) begin
          state_next = ST_IDLE;
          voice_next = '0;
        end else begin
          voice_next = voice_reg + 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Ungated voices are pinned to zero so a later note-on starts from a clean phase.
  assign acc_phase = rd_gate ? (rd_phase + rd_inc) : '0;

  phase_voice_regs #(
    .VOICES (VOICES),
    .PHASE_W(PHASE_W),
    .VOICE_W(VOICE_W)
  ) u_regs (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (i_wr_en),
    .wr_voice (i_wr_voice),
    .wr_inc   (i_wr_inc),
    .wr_gate  (i_wr_gate),
    .upd_en   (busy),
    .upd_voice(voice_reg),
    .upd_phase(acc_phase),
    .rd_phase (rd_phase),
    .rd_inc   (rd_inc),
    .rd_gate  (rd_gate)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_reg     <= 1'b0;
      out_voice_reg <= '0;
      out_phase_reg <= '0;
      active_reg    <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      valid_reg <= busy;
      if (busy) begin
        out_voice_reg <= voice_reg;
        out_phase_reg <= acc_phase;
        active_reg    <= rd_gate;
      end
      if (busy && i_sample_en)
        overrun_reg <= 1'b1;
    end
  end

  assign o_valid   = valid_reg;
  assign o_voice   = out_voice_reg;
  assign o_phase   = out_phase_reg;
  assign o_active  = active_reg;
  assign o_busy    = busy;
  assign o_overrun = overrun_reg;

endmodule

// File: tb/tb_phase_bank.sv
// Directed self-checking bench for phase_bank (VOICES=8, PHASE_W=32).
// Each scenario task drives stimulus and compares against hand-computed values.
module tb_phase_bank;

  localparam int VOICES  = 8;
  localparam int PHASE_W = 32;
  localparam int VOICE_W = 3;
  localparam logic [31:0] A4 = 32'h0B43_9581;

  logic               clk = 1'b0;
  logic               reset;
  logic               i_sample_en;
  logic               i_wr_en;
  logic [VOICE_W-1:0] i_wr_voice;
  logic [PHASE_W-1:0] i_wr_inc;
  logic               i_wr_gate;
  logic               o_valid;
  logic [VOICE_W-1:0] o_voice;
  logic [PHASE_W-1:0] o_phase;
  logic               o_active;
  logic               o_busy;
  logic               o_overrun;

  int checks = 0;
  int errors = 0;

  logic [PHASE_W-1:0] res_phase  [VOICES];
  logic               res_active [VOICES];
  int                 sw_valid_cnt, sw_order_err;
  logic               sw_busy_first, sw_valid_first, sw_busy_after, sw_valid_after;

  always #5 clk = ~clk;

  phase_bank #(.VOICES(VOICES), .PHASE_W(PHASE_W), .VOICE_W(VOICE_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .i_sample_en(i_sample_en),
    .i_wr_en    (i_wr_en),
    .i_wr_voice (i_wr_voice),
    .i_wr_inc   (i_wr_inc),
    .i_wr_gate  (i_wr_gate),
    .o_valid    (o_valid),
    .o_voice    (o_voice),
    .o_phase    (o_phase),
    .o_active   (o_active),
    .o_busy     (o_busy),
    .o_overrun  (o_overrun)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wr(input logic [VOICE_W-1:0] v, input logic [PHASE_W-1:0] inc, input logic g);
    i_wr_en = 1'b1; i_wr_voice = v; i_wr_inc = inc; i_wr_gate = g;
    tick();
    i_wr_en = 1'b0;
  endtask

  // Strobe one sweep and capture the eight results plus framing observations.
  task automatic do_sweep();
    i_sample_en = 1'b1;
    tick();
    i_sample_en = 1'b0;
    sw_busy_first  = o_busy;
    sw_valid_first = o_valid;
    sw_valid_cnt = 0;
    sw_order_err = 0;
    for (int k = 0; k < VOICES; k++) begin
      tick();
      if (o_valid) sw_valid_cnt++;
      if (o_voice !== 3'(k)) sw_order_err++;
      res_phase[k]  = o_phase;
      res_active[k] = o_active;
    end
    tick();
    sw_busy_after  = o_busy;
    sw_valid_after = o_valid;
  endtask

  task automatic test_reset();
    i_sample_en = 1'b1; i_wr_en = 1'b1; i_wr_voice = 3'd1; i_wr_inc = 32'h1234_5678; i_wr_gate = 1'b1;
    reset = 1'b1;
    tick(); tick(); tick();
    i_sample_en = 1'b0; i_wr_en = 1'b0;
    reset = 1'b0;
    checks++; if (o_valid !== 1'b0)   begin errors++; $display("FAIL reset_valid got=%b exp=0", o_valid); end
    checks++; if (o_busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
    checks++; if (o_overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%b exp=0", o_overrun); end
    checks++; if (o_phase !== 32'h0 || o_voice !== 3'd0 || o_active !== 1'b0)
      begin errors++; $display("FAIL reset_outputs got phase=%h voice=%0d act=%b exp 0/0/0", o_phase, o_voice, o_active); end
    tick();
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_strobe_ignored busy=%b exp=0", o_busy); end
    do_sweep();
    checks++; if (res_active[1] !== 1'b0 || res_phase[1] !== 32'h0)
      begin errors++; $display("FAIL reset_write_ignored v1 phase=%h act=%b exp 0/0", res_phase[1], res_active[1]); end
    $display("test_reset done");
  endtask

  task automatic test_a4();
    logic [31:0] exp_ph [3];
    exp_ph[0] = 32'h0B43_9581; exp_ph[1] = 32'h1687_2B02; exp_ph[2] = 32'h21CA_C083;
    do_reset();
    wr(3'd0, A4, 1'b1);
    for (int s = 0; s < 3; s++) begin
      do_sweep();
      checks++; if (sw_busy_first !== 1'b1 || sw_valid_first !== 1'b0)
        begin errors++; $display("FAIL a4_first_cycle s=%0d busy=%b valid=%b exp 1/0", s, sw_busy_first, sw_valid_first); end
      checks++; if (sw_valid_cnt != VOICES || sw_order_err != 0)
        begin errors++; $display("FAIL a4_framing s=%0d valid_cnt=%0d order_err=%0d exp 8/0", s, sw_valid_cnt, sw_order_err); end
      checks++; if (res_phase[0] !== exp_ph[s] || res_active[0] !== 1'b1)
        begin errors++; $display("FAIL a4_voice0 s=%0d phase=%h act=%b exp %h/1", s, res_phase[0], res_active[0], exp_ph[s]); end
      for (int v = 1; v < VOICES; v++) begin
        checks++; if (res_phase[v] !== 32'h0 || res_active[v] !== 1'b0)
          begin errors++; $display("FAIL a4_idle_voice s=%0d v=%0d phase=%h act=%b exp 0/0", s, v, res_phase[v], res_active[v]); end
      end
      checks++; if (sw_valid_after !== 1'b0 || sw_busy_after !== 1'b0)
        begin errors++; $display("FAIL a4_after valid=%b busy=%b exp 0/0", sw_valid_after, sw_busy_after); end
      $display("a4 sweep %0d voice0 phase=%h", s, res_phase[0]);
    end
    checks++; if (o_voice !== 3'd7 || o_phase !== 32'h0)
      begin errors++; $display("FAIL a4_hold voice=%0d phase=%h exp 7/0", o_voice, o_phase); end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_ph [3];
    exp_ph[0] = 32'h8000_0000; exp_ph[1] = 32'h0000_0000; exp_ph[2] = 32'h8000_0000;
    do_reset();
    wr(3'd3, 32'h8000_0000, 1'b1);
    for (int s = 0; s < 3; s++) begin
      do_sweep();
      checks++; if (res_phase[3] !== exp_ph[s] || res_active[3] !== 1'b1)
        begin errors++; $display("FAIL wrap_voice3 s=%0d phase=%h act=%b exp %h/1", s, res_phase[3], res_active[3], exp_ph[s]); end
      $display("wrap sweep %0d voice3 phase=%h", s, res_phase[3]);
    end
  endtask

  task automatic test_overrun();
    int vcnt;
    do_reset();
    vcnt = 0;
    for (int c = 0; c < 14; c++) begin
      i_sample_en = (c == 0 || c == 3);
      tick();
      if (o_valid) vcnt++;
    end
    i_sample_en = 1'b0;
    checks++; if (vcnt != VOICES) begin errors++; $display("FAIL overrun_valid_cycles got=%0d exp=8", vcnt); end
    checks++; if (o_overrun !== 1'b1) begin errors++; $display("FAIL overrun_flag got=%b exp=1", o_overrun); end
    do_sweep();
    checks++; if (o_overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky got=%b exp=1", o_overrun); end
    $display("overrun valid_cycles=%0d flag=%b", vcnt, o_overrun);
  endtask

  task automatic test_retrigger();
    do_reset();
    wr(3'd1, 32'h4000_0000, 1'b1);
    do_sweep();
    checks++; if (res_phase[1] !== 32'h4000_0000)
      begin errors++; $display("FAIL retrig_setup phase=%h exp 40000000", res_phase[1]); end
    wr(3'd1, 32'h4000_0000, 1'b0);
    wr(3'd1, 32'h0100_0000, 1'b1);
    do_sweep();
    checks++; if (res_phase[1] !== 32'h0100_0000 || res_active[1] !== 1'b1)
      begin errors++; $display("FAIL retrig_note_on phase=%h act=%b exp 01000000/1", res_phase[1], res_active[1]); end
    wr(3'd1, 32'h0010_0000, 1'b1);
    do_sweep();
    checks++; if (res_phase[1] !== 32'h0110_0000)
      begin errors++; $display("FAIL retrig_glide phase=%h exp 01100000", res_phase[1]); end
    $display("retrigger voice1 phase=%h", res_phase[1]);
  endtask

  task automatic test_same_cycle();
    logic [31:0] got;
    do_reset();
    wr(3'd2, 32'h0000_0100, 1'b1);
    do_sweep();
    checks++; if (res_phase[2] !== 32'h0000_0100)
      begin errors++; $display("FAIL same_setup phase=%h exp 00000100", res_phase[2]); end
    got = 32'hDEAD_BEEF;
    for (int c = 0; c < 11; c++) begin
      i_sample_en = (c == 0);
      i_wr_en     = (c == 3);
      i_wr_voice  = 3'd2; i_wr_inc = 32'h0001_0000; i_wr_gate = 1'b1;
      tick();
      if (o_valid && o_voice === 3'd2) got = o_phase;
    end
    i_sample_en = 1'b0; i_wr_en = 1'b0;
    checks++; if (got !== 32'h0000_0200)
      begin errors++; $display("FAIL same_old_inc phase=%h exp 00000200", got); end
    do_sweep();
    checks++; if (res_phase[2] !== 32'h0001_0200)
      begin errors++; $display("FAIL same_new_inc phase=%h exp 00010200", res_phase[2]); end
    $display("same_cycle voice2 phases %h then %h", got, res_phase[2]);
  endtask

  task automatic test_reset_mid();
    int vcnt;
    do_reset();
    wr(3'd5, 32'h0000_1000, 1'b1);
    do_sweep();
    vcnt = 0;
    for (int c = 0; c < 5; c++) begin
      i_sample_en = (c == 0);
      reset = (c == 4);
      tick();
    end
    reset = 1'b0; i_sample_en = 1'b0;
    checks++; if (o_valid !== 1'b0 || o_busy !== 1'b0)
      begin errors++; $display("FAIL midreset_stop valid=%b busy=%b exp 0/0", o_valid, o_busy); end
    for (int c = 0; c < 10; c++) begin
      tick();
      if (o_valid) vcnt++;
    end
    checks++; if (vcnt != 0) begin errors++; $display("FAIL midreset_no_valid got=%0d exp=0", vcnt); end
    do_sweep();
    for (int v = 0; v < VOICES; v++) begin
      checks++; if (res_phase[v] !== 32'h0 || res_active[v] !== 1'b0)
        begin errors++; $display("FAIL midreset_cleared v=%0d phase=%h act=%b exp 0/0", v, res_phase[v], res_active[v]); end
    end
    $display("reset_mid done");
  endtask

  initial begin
    reset = 1'b1; i_sample_en = 1'b0; i_wr_en = 1'b0;
    i_wr_voice = '0; i_wr_inc = '0; i_wr_gate = 1'b0;
    test_reset();
    test_a4();
    test_wrap();
    test_overrun();
    test_retrigger();
    test_same_cycle();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/phase_bank.md
PHASE_BANK -- requirements
Module: phase_bank

Interface
REQ-001 SHALL have parameter VOICES, default 8, number of independent phase accumulators (power of two, 2..64).
REQ-002 SHALL have parameter PHASE_W, default 32, accumulator and increment width.
REQ-003 SHALL have parameter VOICE_W, default $clog2(VOICES), voice index width.
REQ-004 SHALL have port clk  in  1  single system clock; all logic on rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port i_sample_en  in  1  one-cycle sample-rate strobe starting a sweep.
REQ-007 SHALL have port i_wr_en  in  1  voice-configuration write strobe.
REQ-008 SHALL have port i_wr_voice  in  VOICE_W  voice targeted by the write.
REQ-009 SHALL have port i_wr_inc  in  PHASE_W  new phase increment (2^PHASE_W * fd / fs).
REQ-010 SHALL have port i_wr_gate  in  1  new gate: 1 = note on, 0 = note off.
REQ-011 SHALL have port o_valid  out  1  o_phase/o_voice/o_active carry a result this cycle.
REQ-012 SHALL have port o_voice  out  VOICE_W  voice index of the current result.
REQ-013 SHALL have port o_phase  out  PHASE_W  post-increment phase of o_voice.
REQ-014 SHALL have port o_active  out  1  gate of o_voice when processed.
REQ-015 SHALL have port o_busy  out  1  high while a sweep is in progress.
REQ-016 SHALL have port o_overrun  out  1  sticky flag: i_sample_en arrived while busy.

Function
REQ-017 SHALL hold per voice: phase[PHASE_W], inc[PHASE_W], gate[1].
REQ-018 SHALL implement FSM IDLE/SWEEP; IDLE -> SWEEP on i_sample_en; SWEEP -> IDLE after voice VOICES-1 is processed.
REQ-019 SHALL process one voice per cycle in SWEEP, ascending from 0, so a sweep lasts exactly VOICES cycles.
REQ-020 SHALL, for a gated voice, set phase <= phase + inc modulo 2^PHASE_W (carry discarded, natural wrap).
REQ-021 SHALL, for an ungated voice, hold phase at 0 and emit o_phase = 0, o_active = 0.
REQ-022 SHALL register outputs: strobe in cycle T gives o_valid high in cycles T+2 .. T+VOICES+1 with o_voice = 0..VOICES-1 in order.
REQ-023 SHALL drive o_valid low and hold o_voice/o_phase/o_active at their last values outside a sweep.
REQ-024 SHALL assert o_busy from cycle T+1 through T+VOICES.
REQ-025 SHALL ignore i_sample_en while busy (no restart, no queuing) and set o_overrun; o_overrun clears only on reset.
REQ-026 SHALL accept writes in any cycle, IDLE or SWEEP; inc and gate update at the end of the write cycle.
REQ-027 SHALL clear phase to 0 on a write whose i_wr_gate is 1 while the stored gate is 0 (note-on retrigger).
REQ-028 SHALL keep phase unchanged on writes that do not rise the gate (glide: new inc applies from next processing).
REQ-029 SHALL, when a write targets the voice being processed in the same cycle, use the old inc/gate for that accumulation; a note-on clear takes priority over the accumulation result.

Reset
REQ-030 SHALL on reset clear all phase, inc, gate; FSM to IDLE; o_valid, o_busy, o_overrun, o_voice, o_phase, o_active to 0.
REQ-031 SHALL abandon a sweep in progress when reset is asserted mid-sweep; no further o_valid until a new strobe after reset deasserts.
REQ-032 SHALL ignore i_sample_en and i_wr_en in any cycle where reset is high.

Structure
REQ-033 SHALL take PHASE_W default and the constant A4_INC = 32'h0B43_9581 (440 Hz at fs ~ 10 kHz-scaled table) from shared package synth_pkg.
REQ-034 SHALL place the per-voice phase/inc/gate storage in one sub-module phase_voice_regs (one write port, one read/modify port).
REQ-035 SHALL contain no clock gating; i_sample_en is the only rate control.

Verification
REQ-036 SHALL cover: write voice 0 inc=A4_INC gate=1, three strobes -> o_phase 0x0B439581, 0x16872B02, 0x21CAC083 for voice 0; other voices o_active=0, o_phase=0.
REQ-037 SHALL cover: voice 3 inc=0x8000_0000 gated, strobes -> o_phase 0x80000000, 0x00000000, 0x80000000 (wrap).
REQ-038 SHALL cover: strobe, second strobe 3 cycles later (VOICES=8) -> exactly 8 o_valid cycles, o_overrun=1 and stays 1.
REQ-039 SHALL cover: gated voice at phase 0x40000000, gate-off then gate-on write -> next result equals inc exactly.
REQ-040 SHALL cover: write to voice 2 in the cycle it is processed -> that result uses old inc, next sweep uses new inc.
REQ-041 SHALL cover: reset asserted at sweep cycle 4 -> o_valid low from next cycle, all phases 0 after reset.
